antares_bus_arbiter_2_1: RTL and testbench



---
 rtl/antares_bus_pkg.sv | 22 ++
 rtl/antares_mux_2_1.sv | 16 +
 rtl/antares_bus_arbiter_2_1.sv | 155 +++++++++++++++
 tb/tb_antares_bus_arbiter_2_1.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/antares_bus_pkg.sv
// Shared definitions for the antares two-master bus arbiter:
// FSM state type, grant identifiers and default bus geometry.
package antares_bus_pkg;

   // Arbiter sequencing states
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_t;

   // Grant identifiers; grant doubles as the mux select for master-to-slave fields
   localparam logic GNT_M0 = 1'b0;
   localparam logic GNT_M1 = 1'b1;

   // Default bus geometry
   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_SEL_W   = 4;
   localparam int DEF_TIMEOUT = 255;
   localparam int DEF_TO_W    = 8;

endpackage : antares_bus_pkg

// File: rtl/antares_mux_2_1.sv
// Generic 2:1 multiplexer used to steer one master-to-slave field.
module antares_mux_2_1 #(
   parameter int W = 32
) (
   input  logic         sel,
   input  logic [W-1:0] d0,
   input  logic [W-1:0] d1,
   output logic [W-1:0] y
);

   // Select d1 when sel is high, otherwise d0
   always_comb begin
      y = sel ? d1 : d0;
   end

endmodule : antares_mux_2_1

// File: rtl/antares_bus_arbiter_2_1.sv
// Two-master / one-slave bus arbiter. Instruction fetch (m0) and data
// access (m1) share one slave port. A two-state FSM sequences each
// transaction, contention is resolved round-robin, and a hung slave is
// released by a timeout that reports an error to the owning master.
module antares_bus_arbiter_2_1
   import antares_bus_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int TO_W    = DEF_TO_W
) (
   input  logic              clk,
   input  logic              rst_n,
   // master 0 (instruction fetch)
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [3:0]        m0_sel,
   input  logic              m0_we,
   input  logic              m0_valid,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_ready,
   output logic              m0_error,
   // master 1 (data access)
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic [3:0]        m1_sel,
   input  logic              m1_we,
   input  logic              m1_valid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_ready,
   output logic              m1_error,
   // slave port
   output logic [ADDR_W-1:0] s_addr,
   output logic [DATA_W-1:0] s_wdata,
   output logic [3:0]        s_sel,
   output logic              s_we,
   output logic              s_valid,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic              s_ready,
   // current owner
   output logic              grant
);

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   arb_state_t      state;
   logic            last;
   logic [TO_W-1:0] to_cnt;
   logic            busy;
   logic            to_hit;
   logic            done;
   logic            ack;

   // Decode the current cycle: a transaction ends either on slave
   // completion or when the timeout expires; s_ready takes priority.
   always_comb begin
      busy   = (state == ST_BUSY);
      ack    = busy && s_ready;
      to_hit = busy && !s_ready && (to_cnt == TO_LAST);
      done   = ack || to_hit;
   end

   // Sequencing FSM with round-robin grant and timeout counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         grant  <= GNT_M0;
         last   <= GNT_M0;
         to_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (m0_valid || m1_valid) begin
                  if (m0_valid && m1_valid) begin
                     grant <= ~last;
                  end else begin
                     grant <= m1_valid ? GNT_M1 : GNT_M0;
                  end
                  to_cnt <= '0;
                  state  <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (done) begin
                  last  <= grant;
                  state <= ST_IDLE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Slave request follows the registered state only
   always_comb begin
      s_valid = busy;
   end

   // Return completion, error and read data to the granted master only
   always_comb begin
      m0_ready = 1'b0;
      m1_ready = 1'b0;
      m0_error = 1'b0;
      m1_error = 1'b0;
      m0_rdata = '0;
      m1_rdata = '0;
      if (grant == GNT_M1) begin
         m1_ready = done;
         m1_error = to_hit;
         if (ack) begin
            m1_rdata = s_rdata;
         end
      end else begin
         m0_ready = done;
         m0_error = to_hit;
         if (ack) begin
            m0_rdata = s_rdata;
         end
      end
   end

   antares_mux_2_1 #(.W(ADDR_W)) u_mux_addr (
      .sel (grant),
      .d0  (m0_addr),
      .d1  (m1_addr),
      .y   (s_addr)
   );

   antares_mux_2_1 #(.W(DATA_W)) u_mux_wdata (
      .sel (grant),
      .d0  (m0_wdata),
      .d1  (m1_wdata),
      .y   (s_wdata)
   );

   antares_mux_2_1 #(.W(4)) u_mux_sel (
      .sel (grant),
      .d0  (m0_sel),
      .d1  (m1_sel),
      .y   (s_sel)
   );

   antares_mux_2_1 #(.W(1)) u_mux_we (
      .sel (grant),
      .d0  (m0_we),
      .d1  (m1_we),
      .y   (s_we)
   );

endmodule : antares_bus_arbiter_2_1

// File: tb/tb_antares_bus_arbiter_2_1.sv
// Self-checking bench for antares_bus_arbiter_2_1: a hand-written vector
// table, directed corner-case sequences and a randomized phase checked
// against a transaction-level reference model.
module tb_antares_bus_arbiter_2_1;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;
   localparam int TW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] m0_addr, m1_addr, s_addr;
   logic [DW-1:0] m0_wdata, m1_wdata, s_wdata;
   logic [3:0]    m0_sel, m1_sel, s_sel;
   logic          m0_we, m1_we, s_we;
   logic          m0_valid, m1_valid, s_valid;
   logic [DW-1:0] m0_rdata, m1_rdata, s_rdata;
   logic          m0_ready, m1_ready, m0_error, m1_error;
   logic          s_ready, grant;

   always #5 clk = ~clk;

   antares_bus_arbiter_2_1 #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .TIMEOUT (TO),
      .TO_W    (TW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .m0_addr  (m0_addr),
      .m0_wdata (m0_wdata),
      .m0_sel   (m0_sel),
      .m0_we    (m0_we),
      .m0_valid (m0_valid),
      .m0_rdata (m0_rdata),
      .m0_ready (m0_ready),
      .m0_error (m0_error),
      .m1_addr  (m1_addr),
      .m1_wdata (m1_wdata),
      .m1_sel   (m1_sel),
      .m1_we    (m1_we),
      .m1_valid (m1_valid),
      .m1_rdata (m1_rdata),
      .m1_ready (m1_ready),
      .m1_error (m1_error),
      .s_addr   (s_addr),
      .s_wdata  (s_wdata),
      .s_sel    (s_sel),
      .s_we     (s_we),
      .s_valid  (s_valid),
      .s_rdata  (s_rdata),
      .s_ready  (s_ready),
      .grant    (grant)
   );

   int total = 0;
   int bad   = 0;

   // Transaction-level model: whether a transfer is open, who owns it,
   // who owned the previous one, and how many cycles it has been open.
   bit md_busy, md_owner, md_last;
   int md_age;

   // Values seen at the last mid-cycle sample
   logic          snap_sval, snap_gnt, snap_we, snap_r0, snap_r1, snap_e0, snap_e1;
   logic [AW-1:0] snap_addr;
   logic [DW-1:0] snap_wdata, snap_rd0, snap_rd1;
   logic [3:0]    snap_sel;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_check(output bit done);
      bit            err;
      logic [DW-1:0] rd;
      done = md_busy && (s_ready || md_age == TO - 1);
      err  = md_busy && !s_ready && md_age == TO - 1;
      rd   = (md_busy && s_ready) ? s_rdata : '0;
      snap_sval = s_valid;  snap_gnt = grant;   snap_we = s_we;
      snap_r0 = m0_ready;   snap_r1 = m1_ready; snap_e0 = m0_error; snap_e1 = m1_error;
      snap_addr = s_addr;   snap_wdata = s_wdata; snap_sel = s_sel;
      snap_rd0 = m0_rdata;  snap_rd1 = m1_rdata;
      check("mdl s_valid", s_valid, md_busy);
      check("mdl grant", grant, md_owner);
      check("mdl s_addr", s_addr, md_owner ? m1_addr : m0_addr);
      check("mdl s_wdata", s_wdata, md_owner ? m1_wdata : m0_wdata);
      check("mdl s_sel", s_sel, md_owner ? m1_sel : m0_sel);
      check("mdl s_we", s_we, md_owner ? m1_we : m0_we);
      check("mdl m0_ready", m0_ready, done && !md_owner);
      check("mdl m1_ready", m1_ready, done && md_owner);
      check("mdl m0_error", m0_error, err && !md_owner);
      check("mdl m1_error", m1_error, err && md_owner);
      check("mdl m0_rdata", m0_rdata, md_owner ? '0 : rd);
      check("mdl m1_rdata", m1_rdata, md_owner ? rd : '0);
   endtask

   task automatic model_advance(input bit done);
      if (!md_busy) begin
         if (m0_valid || m1_valid) begin
            md_owner = (m0_valid && m1_valid) ? !md_last : m1_valid;
            md_busy  = 1'b1;
            md_age   = 0;
         end
      end else if (done) begin
         md_last = md_owner;
         md_busy = 1'b0;
      end else begin
         md_age++;
      end
   endtask

   // One bus cycle: inputs already driven; sample mid-cycle, then clock
   task automatic cycle();
      bit done;
      @(negedge clk);
      model_check(done);
      @(posedge clk);
      model_advance(done);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst s_valid", s_valid, 0);
      check("rst grant", grant, 0);
      check("rst m0_ready", m0_ready, 0);
      check("rst m1_ready", m1_ready, 0);
      check("rst m0_error", m0_error, 0);
      check("rst m1_error", m1_error, 0);
      check("rst m0_rdata", m0_rdata, 0);
      check("rst m1_rdata", m1_rdata, 0);
      md_busy = 1'b0; md_owner = 1'b0; md_last = 1'b0; md_age = 0;
      rst_n = 1'b1;
   endtask

   // Vector record, field order: v0 v1 sr | sv g r0 r1
   typedef struct packed {
      bit v0, v1, sr;
      bit sv, g, r0, r1;
   } vec_t;

   vec_t tbl [13];

   initial begin
      int rise, errc, k;
      bit found;

      tbl[0]  = 7'b100_0000;  // m0 request sampled in IDLE
      tbl[1]  = 7'b100_1000;  // s_valid one cycle later
      tbl[2]  = 7'b100_1000;
      tbl[3]  = 7'b101_1010;  // slave acks, m0_ready + rdata
      tbl[4]  = 7'b000_0000;
      tbl[5]  = 7'b110_0000;  // first contention
      tbl[6]  = 7'b110_1100;  // m1 wins, write in flight
      tbl[7]  = 7'b111_1101;
      tbl[8]  = 7'b110_0100;  // bubble
      tbl[9]  = 7'b111_1010;  // m0 turn
      tbl[10] = 7'b110_0000;  // bubble
      tbl[11] = 7'b011_1101;  // m1 turn; m0 dropped valid
      tbl[12] = 7'b000_0100;

      m0_addr = 32'h0000_0100; m0_wdata = 32'hAAAA_0000; m0_sel = 4'hF;    m0_we = 1'b0;
      m1_addr = 32'h0000_0200; m1_wdata = 32'h0000_1234; m1_sel = 4'b0011; m1_we = 1'b1;
      s_rdata = 32'hDEAD_BEEF;
      do_reset();

      // Vector table
      for (int i = 0; i < 13; i++) begin
         m0_valid = tbl[i].v0; m1_valid = tbl[i].v1; s_ready = tbl[i].sr;
         cycle();
         check($sformatf("tbl%0d s_valid", i), snap_sval, tbl[i].sv);
         check($sformatf("tbl%0d grant", i), snap_gnt, tbl[i].g);
         check($sformatf("tbl%0d m0_ready", i), snap_r0, tbl[i].r0);
         check($sformatf("tbl%0d m1_ready", i), snap_r1, tbl[i].r1);
         check($sformatf("tbl%0d m0_error", i), snap_e0, 0);
         check($sformatf("tbl%0d m1_error", i), snap_e1, 0);
         check($sformatf("tbl%0d m0_rdata", i), snap_rd0, tbl[i].r0 ? 32'hDEAD_BEEF : 32'h0);
         check($sformatf("tbl%0d m1_rdata", i), snap_rd1, tbl[i].r1 ? 32'hDEAD_BEEF : 32'h0);
         check($sformatf("tbl%0d s_addr", i), snap_addr, tbl[i].g ? 32'h200 : 32'h100);
         check($sformatf("tbl%0d s_we", i), snap_we, tbl[i].g);
         check($sformatf("tbl%0d s_sel", i), snap_sel, tbl[i].g ? 4'b0011 : 4'hF);
         check($sformatf("tbl%0d s_wdata", i), snap_wdata, tbl[i].g ? 32'h1234 : 32'hAAAA_0000);
      end

      // Timeout: slave never acks
      m0_valid = 1'b1; m1_valid = 1'b0; s_ready = 1'b0;
      rise = -1; errc = -1;
      for (int i = 0; i < 20 && errc < 0; i++) begin
         cycle();
         if (snap_sval && rise < 0) rise = i;
         if (snap_e0) begin
            errc = i;
            check("to m0_ready with error", snap_r0, 1);
            check("to m0_rdata", snap_rd0, 0);
         end
      end
      check("to error seen", errc >= 0, 1);
      check("to busy cycles until error", errc - rise + 1, TO);
      m0_valid = 1'b0;
      cycle();
      check("to s_valid dropped", snap_sval, 0);
      m1_valid = 1'b1; s_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         cycle();
         found = snap_r1;
      end
      check("to m1 serviced after", found, 1);
      m1_valid = 1'b0; s_ready = 1'b0;
      cycle();

      // s_ready lands on the timeout cycle: normal completion wins
      m0_valid = 1'b1; s_rdata = 32'hCAFE_F00D;
      k = 0; found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         s_ready = (k == TO - 1);
         cycle();
         if (snap_sval) k++;
         if (snap_r0) begin
            found = 1'b1;
            check("coin m0_error", snap_e0, 0);
            check("coin m0_rdata", snap_rd0, 32'hCAFE_F00D);
            check("coin busy cycles", k, TO);
         end
      end
      check("coin completion seen", found, 1);
      m0_valid = 1'b0; s_ready = 1'b0;
      cycle();

      // Asynchronous reset in the middle of an m1 transfer
      m1_valid = 1'b1;
      cycle();
      cycle();
      check("arst pre s_valid", s_valid, 1);
      check("arst pre grant", grant, 1);
      rst_n = 1'b0;
      #1;
      check("arst s_valid", s_valid, 0);
      check("arst grant", grant, 0);
      check("arst m1_ready", m1_ready, 0);
      do_reset();
      m0_valid = 1'b1; m0_addr = 32'h0000_0300; s_ready = 1'b1; s_rdata = 32'h0BAD_F00D;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         cycle();
         if (snap_r0) begin
            found = 1'b1;
            check("arst after m0_rdata", snap_rd0, 32'h0BAD_F00D);
         end
      end
      check("arst after serviced", found, 1);
      m0_valid = 1'b0; s_ready = 1'b0;
      cycle();

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         if (!m0_valid && $urandom_range(2) == 0) begin
            m0_valid = 1'b1; m0_addr = $urandom; m0_wdata = $urandom;
            m0_sel = 4'($urandom); m0_we = 1'($urandom);
         end
         if (!m1_valid && $urandom_range(2) == 0) begin
            m1_valid = 1'b1; m1_addr = $urandom; m1_wdata = $urandom;
            m1_sel = 4'($urandom); m1_we = 1'($urandom);
         end
         s_ready = ($urandom_range(3) == 0);
         s_rdata = $urandom;
         cycle();
         if (snap_r0) m0_valid = 1'b0;
         if (snap_r1) m1_valid = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_antares_bus_arbiter_2_1
